// File: rtl/ad9361_tx_pkg.sv
// ============================================================================
// Module      : ad9361_tx_pkg
// Description : Shared types and constants for the AD9361 TX framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ad9361_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    localparam int NBEATS_1T   = 4;
    localparam int NBEATS_2T   = 8;
    localparam int BEAT_W      = $clog2(NBEATS_2T);
    localparam int UFLOW_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/ad9361_tx_ramp_gen.sv
// ============================================================================
// Module      : ad9361_tx_ramp_gen
// Description : Free-running test ramp; channel 1 carries the inverted count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9361_tx_ramp_gen #(
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic [SAMPLE_WIDTH-1:0] ramp_ch0,
    output logic [SAMPLE_WIDTH-1:0] ramp_ch1
);

    logic [SAMPLE_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (advance) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign ramp_ch0 = r_count;
    assign ramp_ch1 = ~r_count;

endmodule

`default_nettype wire

// File: rtl/ad9361_tx_framer.sv
// ============================================================================
// Module      : ad9361_tx_framer
// Description : Serializes 12-bit I/Q samples into 6-bit AD9361 TX beats with
//               frame marker. Optional ramp source: AD9361_TX_FRAMER_RAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9361_tx_framer #(
    parameter int SAMPLE_WIDTH   = 12,
    parameter int BUS_WIDTH      = 6,
    parameter int UNDERFLOW_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
`ifdef AD9361_TX_FRAMER_RAMP_EN
    input  logic                    ramp_en,
`endif
    input  logic                    r1_mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_i0,
    input  logic [SAMPLE_WIDTH-1:0] s_q0,
    input  logic [SAMPLE_WIDTH-1:0] s_i1,
    input  logic [SAMPLE_WIDTH-1:0] s_q1,
    output logic                    tx_frame,
    output logic [BUS_WIDTH-1:0]    tx_data,
    output logic                    underflow,
    output logic [15:0]             underflow_cnt
);

    import ad9361_tx_pkg::*;

    tx_state_t               r_state;
    logic [BEAT_W-1:0]       r_beat;
    logic                    r_mode_1t;
    logic [SAMPLE_WIDTH-1:0] r_i0, r_q0, r_i1, r_q1;
    logic                    r_underflow;
    logic [UFLOW_CNT_W-1:0]  r_uf_cnt;

    logic [BEAT_W-1:0]       w_last_idx;
    logic                    w_load_slot;
    logic                    w_ramp_sel;
    logic                    w_take;
    logic                    w_starve;
    logic [SAMPLE_WIDTH-1:0] w_ld_i0, w_ld_q0, w_ld_i1, w_ld_q1;
    logic [SAMPLE_WIDTH-1:0] w_word;

    assign w_last_idx  = r_mode_1t ? BEAT_W'(NBEATS_1T - 1) : BEAT_W'(NBEATS_2T - 1);
    assign w_load_slot = enable && ((r_state == ST_START) ||
                                    ((r_state == ST_RUN) && (r_beat == w_last_idx)));
    assign w_take      = w_ramp_sel || s_valid;
    assign w_starve    = w_load_slot && !w_take;
    assign s_ready     = w_load_slot && !w_ramp_sel;

`ifdef AD9361_TX_FRAMER_RAMP_EN
    logic [SAMPLE_WIDTH-1:0] w_ramp_ch0, w_ramp_ch1;

    assign w_ramp_sel = ramp_en;

    // Ramp restarts on every IDLE->START transition.
    ad9361_tx_ramp_gen #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_ramp_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (enable && (r_state == ST_IDLE)),
        .advance  (w_load_slot && ramp_en),
        .ramp_ch0 (w_ramp_ch0),
        .ramp_ch1 (w_ramp_ch1)
    );

    assign w_ld_i0 = ramp_en ? w_ramp_ch0 : s_i0;
    assign w_ld_q0 = ramp_en ? w_ramp_ch0 : s_q0;
    assign w_ld_i1 = ramp_en ? w_ramp_ch1 : s_i1;
    assign w_ld_q1 = ramp_en ? w_ramp_ch1 : s_q1;
`else
    assign w_ramp_sel = 1'b0;
    assign w_ld_i0    = s_i0;
    assign w_ld_q0    = s_q0;
    assign w_ld_i1    = s_i1;
    assign w_ld_q1    = s_q1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_mode_1t   <= 1'b0;
            r_i0        <= '0;
            r_q0        <= '0;
            r_i1        <= '0;
            r_q1        <= '0;
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
        end else begin
            r_underflow <= w_starve;

            if (!enable) begin
                r_state <= ST_IDLE;
                r_beat  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE:  r_state <= ST_START;
                    ST_START: begin
                        r_state <= ST_RUN;
                        r_beat  <= '0;
                    end
                    ST_RUN:   r_beat <= (r_beat == w_last_idx) ? '0 : r_beat + 1'b1;
                    default:  r_state <= ST_IDLE;
                endcase
            end

            // Mode flag follows only real samples; a starved slot keeps the cadence.
            if (w_load_slot) begin
                if (w_take) begin
                    r_i0      <= w_ld_i0;
                    r_q0      <= w_ld_q0;
                    r_i1      <= w_ld_i1;
                    r_q1      <= w_ld_q1;
                    r_mode_1t <= r1_mode;
                end else if (UNDERFLOW_HOLD == 0) begin
                    r_i0 <= '0;
                    r_q0 <= '0;
                    r_i1 <= '0;
                    r_q1 <= '0;
                end
            end

            if (w_starve && (r_uf_cnt != '1)) begin
                r_uf_cnt <= r_uf_cnt + 1'b1;
            end
        end
    end

    // Beat index bit 2 selects channel, bit 1 selects LSB half, bit 0 selects Q.
    always_comb begin
        w_word = r_i0;
        case ({r_beat[2], r_beat[0]})
            2'b00:   w_word = r_i0;
            2'b01:   w_word = r_q0;
            2'b10:   w_word = r_i1;
            default: w_word = r_q1;
        endcase
    end

    assign tx_data  = (r_state != ST_RUN) ? '0 :
                      r_beat[1] ? w_word[BUS_WIDTH-1:0] : w_word[SAMPLE_WIDTH-1:BUS_WIDTH];
    assign tx_frame = (r_state == ST_RUN) && (r_mode_1t ? !r_beat[1] : !r_beat[2]);

    assign underflow     = r_underflow;
    assign underflow_cnt = r_uf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ad9361_tx_framer.sv
// ============================================================================
// Module      : tb_ad9361_tx_framer
// Description : Bench for ad9361_tx_framer (both UNDERFLOW_HOLD settings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ad9361_tx_framer;

    localparam int SW = 12;
    localparam int BW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, r1_mode, s_valid, ramp_en;
    logic [SW-1:0] s_i0, s_q0, s_i1, s_q1;

    logic [1:0]         rdy, frm, ufl;
    logic [1:0][BW-1:0] dat;
    logic [1:0][15:0]   ucnt;

    for (genvar h = 0; h < 2; h++) begin : g_dut
        ad9361_tx_framer #(
            .SAMPLE_WIDTH   (SW),
            .BUS_WIDTH      (BW),
            .UNDERFLOW_HOLD (h)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .enable        (enable),
`ifdef AD9361_TX_FRAMER_RAMP_EN
            .ramp_en       (ramp_en),
`endif
            .r1_mode       (r1_mode),
            .s_valid       (s_valid),
            .s_ready       (rdy[h]),
            .s_i0          (s_i0),
            .s_q0          (s_q0),
            .s_i1          (s_i1),
            .s_q1          (s_q1),
            .tx_frame      (frm[h]),
            .tx_data       (dat[h]),
            .underflow     (ufl[h]),
            .underflow_cnt (ucnt[h])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample words kept as i0,q0,i1,q1; beats derived by position.
    bit         chk_en = 1'b0;
    bit         m_arm, m_run, m_mode, m_uf;
    int         m_pos, m_len = 8, m_cnt, m_ramp;
    bit [11:0]  m_smp [2][4];

    function automatic bit ramp_sel();
`ifdef AD9361_TX_FRAMER_RAMP_EN
        return ramp_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] exp_beat(input int h);
        bit [11:0] word;
        bit [5:0]  d;
        int        k;
        if (!m_run) return 7'd0;
        k    = m_pos % 4;
        word = m_smp[h][(m_pos / 4) * 2 + (k % 2)];
        d    = (k < 2) ? 6'(word / 64) : 6'(word % 64);
        return {(m_pos < m_len / 2), d};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int h = 0; h < 2; h++) begin
                check($sformatf("beat_h%0d", h), {frm[h], dat[h]}, exp_beat(h));
                check($sformatf("ready_h%0d", h), rdy[h],
                      enable && (m_arm || (m_run && m_pos == m_len - 1)) && !ramp_sel());
                check($sformatf("uflow_h%0d", h), ufl[h], m_uf);
                check($sformatf("ucnt_h%0d", h), ucnt[h], m_cnt);
            end
            if (rst) begin
                m_arm = 0; m_run = 0; m_pos = 0; m_len = 8; m_mode = 0;
                m_uf = 0; m_cnt = 0; m_ramp = 0;
                for (int h = 0; h < 2; h++)
                    for (int j = 0; j < 4; j++) m_smp[h][j] = '0;
            end else if (!enable) begin
                m_arm = 0; m_run = 0; m_uf = 0;
            end else if (m_arm || (m_run && m_pos == m_len - 1)) begin
                m_uf = 0;
                if (ramp_sel()) begin
                    for (int h = 0; h < 2; h++) begin
                        m_smp[h][0] = 12'(m_ramp);
                        m_smp[h][1] = 12'(m_ramp);
                        m_smp[h][2] = 12'(m_ramp) ^ 12'hFFF;
                        m_smp[h][3] = 12'(m_ramp) ^ 12'hFFF;
                    end
                    m_ramp = (m_ramp + 1) % 4096;
                    m_mode = r1_mode;
                end else if (s_valid) begin
                    for (int h = 0; h < 2; h++) begin
                        m_smp[h][0] = s_i0; m_smp[h][1] = s_q0;
                        m_smp[h][2] = s_i1; m_smp[h][3] = s_q1;
                    end
                    m_mode = r1_mode;
                end else begin
                    m_uf = 1;
                    if (m_cnt < 65535) m_cnt++;
                    for (int j = 0; j < 4; j++) m_smp[0][j] = '0;
                end
                m_arm = 0; m_run = 1; m_pos = 0;
                m_len = m_mode ? 4 : 8;
            end else if (m_run) begin
                m_pos++; m_uf = 0;
            end else begin
                m_arm = 1; m_ramp = 0; m_uf = 0;
            end
        end
    end

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[0] && n < 40);
        check(tag, rdy[0], 1'b1);
    endtask

    logic [5:0] t1_exp [4];
    logic [5:0] t2_exp [8];
    int         n;

    initial begin
        t1_exp = '{6'h2A, 6'h04, 6'h3C, 6'h23};
        t2_exp = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h3F, 6'h00, 6'h00, 6'h3F};
        rst = 1; enable = 0; r1_mode = 1; s_valid = 0; ramp_en = 0;
        s_i0 = '0; s_q0 = '0; s_i1 = '0; s_q1 = '0;
        drive_next();
        chk_en = 1'b1;
        drive_next();
        @(negedge clk);
        check("reset_data", dat[0], 6'h00);
        check("reset_frame", frm[0], 1'b0);
        check("reset_ready", rdy[0], 1'b0);
        check("reset_ucnt", ucnt[0], 16'h0);

        // 1T continuous stream
        drive_next();
        rst = 0; enable = 1; r1_mode = 1; s_valid = 1;
        s_i0 = 12'hABC; s_q0 = 12'h123; s_i1 = 12'h555; s_q1 = 12'hAAA;
        wait_slot("t1_start", n);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                check("t1_data", dat[0], t1_exp[b]);
                check("t1_frame", frm[0], b < 2);
                if (b == 3) check("t1_ready", rdy[0], 1'b1);
            end

        // 2T sample
        drive_next();
        r1_mode = 0; s_i0 = 12'h001; s_q0 = 12'h002; s_i1 = 12'hFC0; s_q1 = 12'h03F;
        wait_slot("t2_slot", n);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("t2_data", dat[0], t2_exp[b]);
            check("t2_frame", frm[0], b < 4);
        end

        // Two starved slots
        drive_next();
        r1_mode = 1; s_i0 = 12'hABC; s_q0 = 12'h123;
        wait_slot("t3_load", n);
        drive_next();
        s_valid = 0;
        wait_slot("t3_starve1", n);
        wait_slot("t3_starve2", n);
        drive_next();
        s_valid = 1;
        @(negedge clk);
        check("t3_zero_fill", dat[0], 6'h00);
        check("t3_hold_fill", dat[1], 6'h2A);
        check("t3_pulse", ufl[0], 1'b1);
        wait_slot("t3_resume", n);
        check("t3_cnt_h0", ucnt[0], 16'd2);
        check("t3_cnt_h1", ucnt[1], 16'd2);

        // Enable drop at beat 2, then restart
        drive_next();
        drive_next();
        drive_next();
        enable = 0;
        @(negedge clk);
        @(negedge clk);
        check("t4_data", dat[0], 6'h00);
        check("t4_frame", frm[0], 1'b0);
        check("t4_ready", rdy[0], 1'b0);
        drive_next();
        enable = 1;
        wait_slot("t4_restart", n);
        @(negedge clk);
        check("t4_first_beat", dat[0], 6'h2A);

        // Mode toggle mid-sample
        drive_next();
        r1_mode = 0;
        wait_slot("t5_slot_a", n);
        check("t5_tail_len", n, 3);
        wait_slot("t5_slot_b", n);
        check("t5_2t_len", n, 8);

`ifdef AD9361_TX_FRAMER_RAMP_EN
        drive_next();
        enable = 0;
        drive_next();
        enable = 1; ramp_en = 1; r1_mode = 1;
        for (int c = 0; c < 4097 * 4 + 8; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            drive_next();
        end
        ramp_en = 0;
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drive_next();
            rst     = ($urandom_range(0, 399) == 0);
            enable  = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 11) == 0) r1_mode = ~r1_mode;
            s_valid = ($urandom_range(0, 7) != 0);
            s_i0 = 12'($urandom); s_q0 = 12'($urandom);
            s_i1 = 12'($urandom); s_q1 = 12'($urandom);
        end
        drive_next();
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
